path_writer: RTL and testbench

- Downstream of the Dijkstra top block.
- Once the search raises `ready`, this block walks the predecessor vector from destination back to source and buffers the nodes in a local stack.
- It then writes the shortest path to memory in source-to-destination order, preceded by a length word.
- It shares the memory write channel (`mem_write_enable`/`mem_write_ready`) with the rest of the design.

---
 rtl/path_writer_pkg.sv | 22 ++
 rtl/path_stack.sv | 49 ++++
 rtl/path_writer.sv | 198 +++++++++++++++++++
 tb/tb_path_writer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_writer_pkg.sv
// Shared constants and the controller state type for the path writer slice.
`ifndef PATH_WRITER_CONSTANTS
`define PATH_WRITER_CONSTANTS
`define NO_PREVIOUS_NODE '1
`define DEFAULT_MAX_NODES 16
`define DEFAULT_INDEX_WIDTH 5
`define DEFAULT_MADDR_WIDTH 12
`define DEFAULT_MDATA_WIDTH 16
`endif

package path_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WALK,
        WRITE_LEN,
        WRITE_NODE,
        ERR_LEN,
        DONE
    } PathWriterState;

endpackage

// File: rtl/path_stack.sv
// LIFO holding the nodes of the path while it is walked from destination to source.
module path_stack #(
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic                               clear,
    input  logic [INDEX_WIDTH-1:0]             push_data,
    output logic [INDEX_WIDTH-1:0]             top,
    output logic [INDEX_WIDTH-1:0]             below,
    output logic                               empty,
    output logic [$clog2(MAX_NODES+1)-1:0]     count
);

    localparam int COUNT_WIDTH = $clog2(MAX_NODES + 1);
    localparam int PTR_WIDTH   = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam logic [COUNT_WIDTH-1:0] FULL = COUNT_WIDTH'(MAX_NODES);
    localparam logic [COUNT_WIDTH-1:0] ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] TWO  = COUNT_WIDTH'(2);

    logic [INDEX_WIDTH-1:0] entries [MAX_NODES];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && (count != FULL)) begin
            count <= count + ONE;
        end else if (pop && (count != '0)) begin
            count <= count - ONE;
        end
    end

    // Storage carries no reset; only the occupancy count defines valid entries.
    always_ff @(posedge clock) begin
        if (push && !clear && (count != FULL)) begin
            entries[PTR_WIDTH'(count)] <= push_data;
        end
    end

    assign empty = (count == '0);
    assign top   = (count >= ONE) ? entries[PTR_WIDTH'(count - ONE)] : '0;
    assign below = (count >= TWO) ? entries[PTR_WIDTH'(count - TWO)] : '0;

endmodule

// File: rtl/path_writer.sv
// Walks the Dijkstra predecessor vector from destination to source, then writes
// a length word followed by the path in source-to-destination order.
module path_writer
    import path_writer_pkg::*;
#(
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [INDEX_WIDTH-1:0]                source,
    input  logic [INDEX_WIDTH-1:0]                destination,
    input  logic [INDEX_WIDTH-1:0]                number_of_nodes,
    input  logic [MADDR_WIDTH-1:0]                base_address,
    input  logic [MAX_NODES-1:0][INDEX_WIDTH-1:0] prev_vector,
    output logic                                  mem_write_enable,
    input  logic                                  mem_write_ready,
    output logic [MADDR_WIDTH-1:0]                mem_addr,
    output logic [MDATA_WIDTH-1:0]                mem_write_data,
    output logic [INDEX_WIDTH:0]                  path_length,
    output logic                                  error,
    output logic                                  done
);

    localparam int COUNT_WIDTH = $clog2(MAX_NODES + 1);
    localparam logic [INDEX_WIDTH-1:0] NO_PREV  = `NO_PREVIOUS_NODE;
    localparam logic [INDEX_WIDTH:0]   CAPACITY = (INDEX_WIDTH + 1)'(MAX_NODES);
    localparam logic [INDEX_WIDTH:0]   HOP_ONE  = (INDEX_WIDTH + 1)'(1);
    localparam logic [MADDR_WIDTH-1:0] ADDR_ONE = MADDR_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] LAST     = COUNT_WIDTH'(1);

    PathWriterState         state;
    logic [INDEX_WIDTH-1:0] src_q;
    logic [INDEX_WIDTH-1:0] nodes_q;
    logic [MADDR_WIDTH-1:0] base_q;
    logic [INDEX_WIDTH-1:0] cursor;
    logic [INDEX_WIDTH:0]   hop_count;
    logic [INDEX_WIDTH:0]   hop_next;
    logic [INDEX_WIDTH-1:0] pred;
    logic                   accept;
    logic                   bad_request;

    logic                   stack_push;
    logic                   stack_pop;
    logic                   stack_clear;
    logic [INDEX_WIDTH-1:0] stack_top;
    logic [INDEX_WIDTH-1:0] stack_below;
    logic                   stack_empty;
    logic [COUNT_WIDTH-1:0] stack_count;

    function automatic logic [INDEX_WIDTH-1:0] pred_of(input logic [INDEX_WIDTH-1:0] node);
        pred_of = NO_PREV;
        for (int i = 0; i < MAX_NODES; i++) begin
            if (node == INDEX_WIDTH'(i)) begin
                pred_of = prev_vector[i];
            end
        end
    endfunction

    function automatic logic [MDATA_WIDTH-1:0] widen(input logic [INDEX_WIDTH:0] value);
        return MDATA_WIDTH'(value);
    endfunction

    // A predecessor that points outside the active node set is treated as "none".
    assign pred        = (cursor < nodes_q) ? pred_of(cursor) : NO_PREV;
    assign hop_next    = hop_count + HOP_ONE;
    assign accept      = mem_write_enable && mem_write_ready;
    assign bad_request = (source >= number_of_nodes) || (destination >= number_of_nodes) ||
                         ({1'b0, number_of_nodes} > CAPACITY);

    always_comb begin
        stack_push  = (state == WALK);
        stack_pop   = (state == WRITE_NODE) && accept && !stack_empty;
        stack_clear = 1'b0;
        if (((state == IDLE) || (state == DONE)) && start) begin
            stack_clear = 1'b1;
        end
        if ((state == ERR_LEN) && accept) begin
            stack_clear = 1'b1;
        end
    end

    path_stack #(
        .MAX_NODES   (MAX_NODES),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (stack_push),
        .pop       (stack_pop),
        .clear     (stack_clear),
        .push_data (cursor),
        .top       (stack_top),
        .below     (stack_below),
        .empty     (stack_empty),
        .count     (stack_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            src_q            <= '0;
            nodes_q          <= '0;
            base_q           <= '0;
            cursor           <= '0;
            hop_count        <= '0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_write_data   <= '0;
            path_length      <= '0;
            error            <= 1'b0;
            done             <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        src_q       <= source;
                        nodes_q     <= number_of_nodes;
                        base_q      <= base_address;
                        cursor      <= destination;
                        hop_count   <= '0;
                        path_length <= '0;
                        error       <= 1'b0;
                        done        <= 1'b0;
                        if (bad_request) begin
                            state            <= ERR_LEN;
                            mem_write_enable <= 1'b1;
                            mem_addr         <= base_address;
                            mem_write_data   <= '0;
                        end else begin
                            state <= WALK;
                        end
                    end
                end

                WALK: begin
                    hop_count <= hop_next;
                    if (cursor == src_q) begin
                        state            <= WRITE_LEN;
                        mem_write_enable <= 1'b1;
                        mem_addr         <= base_q;
                        mem_write_data   <= widen(hop_next);
                    end else if ((pred == NO_PREV) || (hop_next == {1'b0, nodes_q})) begin
                        state            <= ERR_LEN;
                        mem_write_enable <= 1'b1;
                        mem_addr         <= base_q;
                        mem_write_data   <= '0;
                    end else begin
                        cursor <= pred;
                    end
                end

                // The stack top is the source, so the first node word needs no pop yet.
                WRITE_LEN: begin
                    if (accept) begin
                        path_length    <= hop_count;
                        state          <= WRITE_NODE;
                        mem_addr       <= mem_addr + ADDR_ONE;
                        mem_write_data <= widen({1'b0, stack_top});
                    end
                end

                // The entry below the top becomes the next word, allowing back-to-back writes.
                WRITE_NODE: begin
                    if (accept) begin
                        if (stack_count == LAST) begin
                            state            <= DONE;
                            mem_write_enable <= 1'b0;
                            done             <= 1'b1;
                        end else begin
                            mem_addr       <= mem_addr + ADDR_ONE;
                            mem_write_data <= widen({1'b0, stack_below});
                        end
                    end
                end

                ERR_LEN: begin
                    if (accept) begin
                        state            <= DONE;
                        mem_write_enable <= 1'b0;
                        error            <= 1'b1;
                        path_length      <= '0;
                        done             <= 1'b1;
                    end
                end

                default: begin
                    state            <= IDLE;
                    mem_write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_writer.sv
// Bench for path_writer: directed scenarios plus random graphs against a path-search model.
module tb_path_writer;

    localparam int MAX_NODES   = 16;
    localparam int INDEX_WIDTH = 5;
    localparam int MADDR_WIDTH = 12;
    localparam int MDATA_WIDTH = 16;
    localparam logic [INDEX_WIDTH-1:0] NOPREV = '1;

    logic                                  clock;
    logic                                  reset;
    logic                                  start;
    logic [INDEX_WIDTH-1:0]                source;
    logic [INDEX_WIDTH-1:0]                destination;
    logic [INDEX_WIDTH-1:0]                number_of_nodes;
    logic [MADDR_WIDTH-1:0]                base_address;
    logic [MAX_NODES-1:0][INDEX_WIDTH-1:0] prev_vector;
    logic                                  mem_write_enable;
    logic                                  mem_write_ready;
    logic [MADDR_WIDTH-1:0]                mem_addr;
    logic [MDATA_WIDTH-1:0]                mem_write_data;
    logic [INDEX_WIDTH:0]                  path_length;
    logic                                  error;
    logic                                  done;

    path_writer #(
        .MAX_NODES   (MAX_NODES),
        .INDEX_WIDTH (INDEX_WIDTH),
        .MADDR_WIDTH (MADDR_WIDTH),
        .MDATA_WIDTH (MDATA_WIDTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .source           (source),
        .destination      (destination),
        .number_of_nodes  (number_of_nodes),
        .base_address     (base_address),
        .prev_vector      (prev_vector),
        .mem_write_enable (mem_write_enable),
        .mem_write_ready  (mem_write_ready),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .path_length      (path_length),
        .error            (error),
        .done             (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests = 0;
    int fails = 0;
    int ready_mode = 0;
    int got_addr[$];
    int got_data[$];
    int exp_addr[$];
    int exp_data[$];
    int exp_len;
    int exp_err;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory-side driver and write monitor; writes are recorded at the negedge
    // before the posedge that accepts them.
    initial begin
        int stall = 0;
        logic hold_pending = 1'b0;
        int hold_addr = 0;
        int hold_data = 0;
        mem_write_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (hold_pending && reset) begin
                check("hold_enable", int'(mem_write_enable), 1);
                check("hold_addr", int'(mem_addr), hold_addr);
                check("hold_data", int'(mem_write_data), hold_data);
            end
            case (ready_mode)
                0: mem_write_ready = 1'b1;
                1: mem_write_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!mem_write_enable) begin
                        mem_write_ready = 1'b0;
                        stall = 0;
                    end else if (stall < 3) begin
                        mem_write_ready = 1'b0;
                        stall++;
                    end else begin
                        mem_write_ready = 1'b1;
                        stall = 0;
                    end
                end
            endcase
            hold_pending = reset && mem_write_enable && !mem_write_ready;
            hold_addr = int'(mem_addr);
            hold_data = int'(mem_write_data);
            if (reset && mem_write_enable && mem_write_ready) begin
                got_addr.push_back(int'(mem_addr));
                got_data.push_back(int'(mem_write_data));
            end
        end
    end

    // Reference: follow predecessors from the destination, then emit length and path.
    function automatic void build_expected(input int src, input int dst, input int n, input int base);
        int path[$];
        int node;
        int p;
        bit ok = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        if (n <= MAX_NODES && src < n && dst < n) begin
            node = dst;
            while (1) begin
                path.push_front(node);
                if (node == src) begin
                    ok = 1'b1;
                    break;
                end
                p = (node < n) ? int'(prev_vector[node]) : int'(NOPREV);
                if (p == int'(NOPREV) || path.size() == n) break;
                node = p;
            end
        end
        if (ok) begin
            exp_len = path.size();
            exp_err = 0;
            exp_addr.push_back(base);
            exp_data.push_back(exp_len);
            for (int k = 1; k <= exp_len; k++) begin
                exp_addr.push_back((base + k) % (1 << MADDR_WIDTH));
                exp_data.push_back(path[k-1]);
            end
        end else begin
            exp_len = 0;
            exp_err = 1;
            exp_addr.push_back(base);
            exp_data.push_back(0);
        end
    endfunction

    task automatic wait_done(input string name);
        int c = 0;
        while (!done && c < 3000) begin
            @(negedge clock);
            c++;
        end
        check({name, "_done"}, int'(done), 1);
    endtask

    task automatic compare_writes(input string name);
        int m;
        check({name, "_nwrites"}, got_addr.size(), exp_addr.size());
        m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            check({name, "_addr"}, got_addr[i], exp_addr[i]);
            check({name, "_data"}, got_data[i], exp_data[i]);
        end
        check({name, "_path_length"}, int'(path_length), exp_len);
        check({name, "_error"}, int'(error), exp_err);
        check({name, "_enable_idle"}, int'(mem_write_enable), 0);
    endtask

    task automatic launch(input int src, input int dst, input int n, input int base);
        build_expected(src, dst, n, base);
        @(negedge clock);
        source          = INDEX_WIDTH'(src);
        destination     = INDEX_WIDTH'(dst);
        number_of_nodes = INDEX_WIDTH'(n);
        base_address    = MADDR_WIDTH'(base);
        got_addr.delete();
        got_data.delete();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_case(input int src, input int dst, input int n, input int base, input string name);
        launch(src, dst, n, base);
        check({name, "_busy"}, int'(done), 0);
        wait_done(name);
        compare_writes(name);
    endtask

    task automatic graph_chain();
        prev_vector = '1;
        prev_vector[1] = 5'd0;
        prev_vector[2] = 5'd1;
        prev_vector[3] = 5'd2;
    endtask

    initial begin
        int n, src, dst, kind, base, c;
        reset = 1'b0;
        start = 1'b0;
        source = '0;
        destination = '0;
        number_of_nodes = '0;
        base_address = '0;
        prev_vector = '1;
        repeat (3) @(negedge clock);
        check("rst_enable", int'(mem_write_enable), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_path_length", int'(path_length), 0);
        check("rst_addr", int'(mem_addr), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_enable", int'(mem_write_enable), 0);

        ready_mode = 0;
        graph_chain();
        run_case(0, 3, 5, 'h100, "found");
        run_case(0, 4, 5, 'h100, "unreachable");
        run_case(2, 2, 5, 'h100, "same_node");
        run_case(0, 3, 5, 'hFFD, "wrap");
        run_case(0, 7, 5, 'h100, "dest_range");
        ready_mode = 2;
        run_case(0, 3, 5, 'h100, "backpressure");
        ready_mode = 0;
        prev_vector = '1;
        prev_vector[0] = 5'd1;
        prev_vector[1] = 5'd0;
        run_case(2, 0, 3, 'h040, "loop");

        // Abort inside the node-write phase.
        ready_mode = 2;
        graph_chain();
        launch(0, 3, 5, 'h100);
        c = 0;
        while (got_addr.size() < 2 && c < 200) begin
            @(negedge clock);
            c++;
        end
        check("abort_reached", (got_addr.size() >= 2) ? 1 : 0, 1);
        @(posedge clock);
        #2;
        check("abort_pre_enable", int'(mem_write_enable), 1);
        reset = 1'b0;
        #1;
        check("abort_enable", int'(mem_write_enable), 0);
        check("abort_done", int'(done), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_rel_done", int'(done), 0);
        check("abort_rel_error", int'(error), 0);
        check("abort_rel_enable", int'(mem_write_enable), 0);
        ready_mode = 0;
        run_case(0, 3, 5, 'h100, "rerun");

        // Start held high through DONE restarts immediately.
        build_expected(0, 3, 5, 'h080);
        @(negedge clock);
        source = 5'd0;
        destination = 5'd3;
        number_of_nodes = 5'd5;
        base_address = 12'h080;
        got_addr.delete();
        got_data.delete();
        start = 1'b1;
        @(negedge clock);
        wait_done("held_first");
        compare_writes("held_first");
        @(negedge clock);
        check("held_restart_done", int'(done), 0);
        got_addr.delete();
        got_data.delete();
        start = 1'b0;
        wait_done("held_second");
        compare_writes("held_second");

        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(1, MAX_NODES);
            if (i % 10 == 9) n = $urandom_range(0, 1) ? 0 : $urandom_range(MAX_NODES + 1, 31);
            kind = $urandom_range(0, 2);
            for (int j = 0; j < MAX_NODES; j++) begin
                if (kind == 0) begin
                    prev_vector[j] = (j == 0) ? NOPREV : INDEX_WIDTH'($urandom_range(0, j - 1));
                end else if (kind == 1) begin
                    prev_vector[j] = ($urandom_range(0, 3) == 0) ? NOPREV
                                   : INDEX_WIDTH'($urandom_range(0, (n > 0) ? n - 1 : 0));
                end else begin
                    prev_vector[j] = INDEX_WIDTH'($urandom_range(0, 31));
                end
            end
            src = (kind == 0 && $urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, n);
            dst = $urandom_range(0, n);
            base = $urandom_range(0, (1 << MADDR_WIDTH) - 1);
            ready_mode = $urandom_range(0, 2);
            run_case(src, dst, n, base, "rand");
        end

        ready_mode = 0;
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
